// File: rtl/tsn_queue_ready_manager.sv
// Per-(port, queue) buffer-address FIFOs with a registered, gate-qualified ready vector
// and a strict-priority pick of the highest ready queue on each port.
module tsn_queue_ready_manager #(
    parameter int NUM_PORTS  = 3,
    parameter int NUM_QUEUES = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 16
) (
    input  logic                                     clk_in,
    input  logic                                     rst,
    input  logic                                     enq_vld_i,
    input  logic [$clog2(NUM_PORTS)-1:0]             enq_port_i,
    input  logic [$clog2(NUM_QUEUES)-1:0]            enq_queue_i,
    input  logic [ADDR_W-1:0]                        enq_addr_i,
    input  logic                                     deq_vld_i,
    input  logic [$clog2(NUM_PORTS)-1:0]             deq_port_i,
    input  logic [$clog2(NUM_QUEUES)-1:0]            deq_queue_i,
    input  logic [NUM_PORTS*NUM_QUEUES-1:0]          gate_state_i,
    output logic [NUM_PORTS*NUM_QUEUES-1:0]          queue_o_rdy,
    output logic [ADDR_W-1:0]                        deq_addr_o,
    output logic                                     deq_vld_o,
    output logic                                     deq_err_o,
    output logic                                     drop_o,
    output logic [CNT_W-1:0]                         drop_cnt_o,
    output logic [NUM_PORTS-1:0]                     sel_vld_o,
    output logic [NUM_PORTS*$clog2(NUM_QUEUES)-1:0]  sel_queue_o
);
    localparam int NQ    = NUM_PORTS * NUM_QUEUES;
    localparam int PW    = $clog2(NUM_PORTS);
    localparam int QW    = $clog2(NUM_QUEUES);
    localparam int IW    = $clog2(NQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [PW:0]   P_LIM = (PW + 1)'(NUM_PORTS);
    localparam logic [QW:0]   Q_LIM = (QW + 1)'(NUM_QUEUES);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [ADDR_W-1:0] mem [NQ*DEPTH];
    logic [PTR_W-1:0]  wptr [NQ];
    logic [PTR_W-1:0]  rptr [NQ];
    logic [CW-1:0]     cnt [NQ];
    logic [CW-1:0]     cnt_n [NQ];

    logic          enq_in, deq_in, enq_ok, deq_ok, drop;
    logic [IW-1:0] enq_idx, deq_idx;

    always_comb begin
        enq_in  = enq_vld_i && ({1'b0, enq_port_i} < P_LIM) && ({1'b0, enq_queue_i} < Q_LIM);
        deq_in  = deq_vld_i && ({1'b0, deq_port_i} < P_LIM) && ({1'b0, deq_queue_i} < Q_LIM);
        enq_idx = IW'(enq_port_i) * IW'(NUM_QUEUES) + IW'(enq_queue_i);
        deq_idx = IW'(deq_port_i) * IW'(NUM_QUEUES) + IW'(deq_queue_i);
        deq_ok  = deq_in && (cnt[deq_idx] != '0);
        // A dequeue on the same full queue frees the slot the enqueue needs.
        enq_ok  = enq_in && ((cnt[enq_idx] != FULL) || (deq_ok && (deq_idx == enq_idx)));
        drop    = enq_in && !enq_ok;
        for (int k = 0; k < NQ; k++) begin
            cnt_n[k] = cnt[k];
            if (enq_ok && (enq_idx == IW'(k))) cnt_n[k] = cnt_n[k] + CW'(1);
            if (deq_ok && (deq_idx == IW'(k))) cnt_n[k] = cnt_n[k] - CW'(1);
        end
    end

    // Descriptor storage is deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (enq_ok) mem[{enq_idx, wptr[enq_idx]}] <= enq_addr_i;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NQ; k++) begin
                cnt[k]  <= '0;
                wptr[k] <= '0;
                rptr[k] <= '0;
            end
            queue_o_rdy <= '0;
            deq_addr_o  <= '0;
            deq_vld_o   <= 1'b0;
            deq_err_o   <= 1'b0;
            drop_o      <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            for (int k = 0; k < NQ; k++) begin
                cnt[k]         <= cnt_n[k];
                queue_o_rdy[k] <= (cnt_n[k] != '0) && gate_state_i[k];
            end
            if (enq_ok) wptr[enq_idx] <= wptr[enq_idx] + PTR_W'(1);
            if (deq_ok) begin
                rptr[deq_idx] <= rptr[deq_idx] + PTR_W'(1);
                deq_addr_o    <= mem[{deq_idx, rptr[deq_idx]}];
            end
            deq_vld_o <= deq_ok;
            deq_err_o <= deq_in && !deq_ok;
            drop_o    <= drop;
            if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
        end
    end

    // Later (higher) indices overwrite earlier ones, leaving the top ready queue.
    always_comb begin
        sel_vld_o   = '0;
        sel_queue_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (queue_o_rdy[p*NUM_QUEUES + q]) begin
                    sel_vld_o[p]              = 1'b1;
                    sel_queue_o[p*QW +: QW]   = QW'(q);
                end
            end
        end
    end
endmodule
